sum_fifo: RTL and testbench

Registered output buffer sitting directly downstream of the chip's combinational 8-bit operand adder (`uo_out = ui_in + uio_in`). Each clock with `in_valid` high, it captures the adder result into a small circular FIFO and presents it to a consumer over a valid/ready handshake. This decouples pin-sampled sums from the output side. The upstream adder has no back-pressure, so a push into a full FIFO is dropped and flagged, never stalled.

---
 rtl/sum_fifo_pkg.sv | 20 ++
 rtl/sum_fifo_if.sv | 48 ++++
 rtl/sum_fifo_mem.sv | 27 ++
 rtl/sum_fifo.sv | 109 ++++++++++
 tb/tb_sum_fifo.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_fifo_pkg.sv
// sum_fifo_pkg: shared constants and types for the adder output buffer.
// Default width/depth, the occupancy counter type, and the drop-counter
// saturation value used by the optional statistics logic.
package sum_fifo_pkg;

    localparam int SUM_WIDTH      = 8;
    localparam int SUM_FIFO_DEPTH = 4;

    // Occupancy runs 0..DEPTH inclusive, so one bit more than a pointer.
    localparam int SUM_CNT_W = $clog2(SUM_FIFO_DEPTH) + 1;
    typedef logic [SUM_CNT_W-1:0] count_t;

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    // Saturating increment for the 8-bit drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sum_fifo_if.sv
// sum_fifo_if: push/pop handshake bundle between the adder, the buffer and
// its consumer. The drop counter exists only when SUM_FIFO_STATS_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. On the push side the producer never waits, so in_valid with
// in_ready low is a dropped push, not a stall. On the pop side out_data is
// held stable while out_valid is high and out_ready is low.
interface sum_fifo_if
    import sum_fifo_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH,
    parameter int DEPTH = SUM_FIFO_DEPTH
);

    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     ovf;
    logic                     ovf_clr;
`ifdef SUM_FIFO_STATS_EN
    logic [7:0]               drop_cnt;
`endif

`ifdef SUM_FIFO_STATS_EN
    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output in_ready, out_valid, out_data, count, ovf, drop_cnt
    );
    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  in_ready, out_valid, out_data, count, ovf, drop_cnt
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output in_ready, out_valid, out_data, count, ovf
    );
    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  in_ready, out_valid, out_data, count, ovf
    );
`endif

endinterface

// File: rtl/sum_fifo_mem.sv
// sum_fifo_mem: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module sum_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the pushed sum into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sum_fifo.sv
// sum_fifo: registered circular buffer behind the 8-bit operand adder.
// Pushes into a full buffer are dropped and flagged on the sticky ovf bit;
// the upstream adder is never stalled.
// Optional feature macro: SUM_FIFO_STATS_EN adds a saturating drop counter.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module sum_fifo
    import sum_fifo_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH,
    parameter int DEPTH = SUM_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    sum_fifo_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic             full;
    logic             empty;
    logic             in_ready;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] rdata;

    // Occupancy flags and handshake qualifiers. in_ready looks through
    // out_ready so a full buffer can still take a push while it is being
    // drained in the same cycle.
    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        in_ready = !full || bus.out_ready;
        push     = bus.in_valid && in_ready;
        pop      = !empty && bus.out_ready;
        drop     = bus.in_valid && !in_ready;
    end

    // Pointers, explicit occupancy count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef SUM_FIFO_STATS_EN
    logic [7:0] drop_cnt_q;

    // Saturating count of dropped pushes; clear plus drop restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else if (drop) begin
            drop_cnt_q <= bus.ovf_clr ? 8'd1 : sat_inc8(drop_cnt_q);
        end else if (bus.ovf_clr) begin
            drop_cnt_q <= 8'd0;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    sum_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = !empty;
    assign bus.out_data  = rdata;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sum_fifo.sv
// tb_sum_fifo: self-checking bench for sum_fifo. Inputs change on the falling
// edge; outputs are observed 1 ns later, away from the rising edge. Build with
// SUM_FIFO_STATS_EN defined to cover the drop counter as well.
module tb_sum_fifo;
    import sum_fifo_pkg::*;

    localparam int W = SUM_WIDTH;
    localparam int D = SUM_FIFO_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: sums accepted by the reference model, oldest first.
    logic [W-1:0] exp_q[$];

    sum_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sum_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Driver for one clock cycle: apply inputs, check the handshake against
    // the model, update the scoreboard, then advance to the next falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d,
                         input logic rdy, input logic clr);
        logic         exp_rdy;
        logic         exp_vld;
        logic [W-1:0] e;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        #1;
        exp_rdy = (exp_q.size() != D) || rdy;
        exp_vld = (exp_q.size() != 0);
        n_checks++;
        if (bus.in_ready !== exp_rdy)
            $display("FAIL in_ready: got %b expected %b", bus.in_ready, exp_rdy);
        else
            n_pass++;
        n_checks++;
        if (bus.out_valid !== exp_vld)
            $display("FAIL out_valid: got %b expected %b", bus.out_valid, exp_vld);
        else
            n_pass++;
        if (exp_vld && rdy) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_data !== e)
                $display("FAIL out_data: got %h expected %h", bus.out_data, e);
            else
                n_pass++;
        end
        if (v && exp_rdy) exp_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Synchronous reset for one edge, optionally with a push that must vanish.
    task automatic do_reset(input logic v, input logic [W-1:0] d);
        rst           = 1'b1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        #1;
    endtask

    task automatic test_reset();
        do_reset(1'b0, '0);
        n_checks++;
        if (bus.count !== count_t'(0)) $display("FAIL reset_count: got %0d expected 0", bus.count); else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_checks++;
        if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus.ovf); else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
`ifdef SUM_FIFO_STATS_EN
        n_checks++;
        if (bus.drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); else n_pass++;
`endif
    endtask

    task automatic test_basic();
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== count_t'(3)) $display("FAIL basic_count: got %0d expected 3", bus.count); else n_pass++;
        n_checks++;
        if (bus.out_data !== 8'h11) $display("FAIL basic_head: got %h expected 11", bus.out_data); else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); else n_pass++;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== count_t'(0)) $display("FAIL basic_drained_count: got %0d expected 0", bus.count); else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_drained_valid: got %b expected 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.ovf !== 1'b1) $display("FAIL ovf_set: got %b expected 1", bus.ovf); else n_pass++;
        n_checks++;
        if (bus.count !== count_t'(4)) $display("FAIL ovf_count: got %0d expected 4", bus.count); else n_pass++;
        n_checks++;
        if (bus.out_data !== 8'h41) $display("FAIL ovf_head: got %h expected 41", bus.out_data); else n_pass++;
`ifdef SUM_FIFO_STATS_EN
        n_checks++;
        if (bus.drop_cnt !== 8'd1) $display("FAIL ovf_drop_cnt: got %0d expected 1", bus.drop_cnt); else n_pass++;
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", bus.ovf); else n_pass++;
`ifdef SUM_FIFO_STATS_EN
        n_checks++;
        if (bus.drop_cnt !== 8'd0) $display("FAIL ovf_clear_drop_cnt: got %0d expected 0", bus.drop_cnt); else n_pass++;
`endif
    endtask

    // Starts full with 41..44 left behind by test_overflow.
    task automatic test_full_push_pop();
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== count_t'(4)) $display("FAIL fullpp_count: got %0d expected 4", bus.count); else n_pass++;
        n_checks++;
        if (bus.ovf !== 1'b0) $display("FAIL fullpp_ovf: got %b expected 0", bus.ovf); else n_pass++;
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.out_data !== 8'hAA) $display("FAIL fullpp_fourth: got %h expected aa", bus.out_data); else n_pass++;
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== count_t'(0)) $display("FAIL fullpp_drained: got %0d expected 0", bus.count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
            #1;
            n_checks++;
            if (bus.count !== count_t'(1)) $display("FAIL b2b_count_%0d: got %0d expected 1", i, bus.count); else n_pass++;
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== count_t'(0)) $display("FAIL b2b_final_count: got %0d expected 0", bus.count); else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h65, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== count_t'(3)) $display("FAIL mrst_pre_count: got %0d expected 3", bus.count); else n_pass++;
        n_checks++;
        if (bus.ovf !== 1'b1) $display("FAIL mrst_pre_ovf: got %b expected 1", bus.ovf); else n_pass++;
        do_reset(1'b1, 8'h77);
        n_checks++;
        if (bus.count !== count_t'(0)) $display("FAIL mrst_count: got %0d expected 0", bus.count); else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_checks++;
        if (bus.ovf !== 1'b0) $display("FAIL mrst_ovf: got %b expected 0", bus.ovf); else n_pass++;
        cycle(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== count_t'(0)) $display("FAIL mrst_push_ignored: got %0d expected 0", bus.count); else n_pass++;
    endtask

    task automatic test_ovf_clr();
        int n_drops;
`ifdef SUM_FIFO_STATS_EN
        n_drops = 300;
`else
        n_drops = 3;
`endif
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < n_drops; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.ovf !== 1'b1) $display("FAIL clr_pre_ovf: got %b expected 1", bus.ovf); else n_pass++;
`ifdef SUM_FIFO_STATS_EN
        n_checks++;
        if (bus.drop_cnt !== 8'd255) $display("FAIL clr_saturate: got %0d expected 255", bus.drop_cnt); else n_pass++;
`endif
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.ovf !== 1'b1) $display("FAIL clr_drop_wins: got %b expected 1", bus.ovf); else n_pass++;
`ifdef SUM_FIFO_STATS_EN
        n_checks++;
        if (bus.drop_cnt !== 8'd1) $display("FAIL clr_drop_cnt: got %0d expected 1", bus.drop_cnt); else n_pass++;
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.ovf !== 1'b0) $display("FAIL clr_alone: got %b expected 0", bus.ovf); else n_pass++;
        n_checks++;
        if (bus.out_data !== 8'h80) $display("FAIL clr_head: got %h expected 80", bus.out_data); else n_pass++;
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_mid_reset();
        test_ovf_clr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
